// File: rtl/cnn_layer_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : cnn_layer_scheduler                                           |
// | Description : Runs the conv/pool/fc engines in ascending order and shares   |
// |               the single AHB master port among them. Optional watchdog      |
// |               is compiled in with CNN_LAYER_SCHED_WATCHDOG_EN.              |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module cnn_layer_scheduler #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  layer_en,
    output logic        busy,
    output logic        done,
    output logic [1:0]  cur_layer,
    output logic        error,
    output logic        e0_start,
    output logic        e1_start,
    output logic        e2_start,
    output logic        e0_rst_n,
    output logic        e1_rst_n,
    output logic        e2_rst_n,
    input  logic        e0_finish,
    input  logic        e1_finish,
    input  logic        e2_finish,
    input  logic [31:0] e0_haddr,
    input  logic [2:0]  e0_hburst,
    input  logic [3:0]  e0_hprot,
    input  logic        e0_hready_in,
    input  logic [2:0]  e0_hsize,
    input  logic [1:0]  e0_htrans,
    input  logic [31:0] e0_hwdata,
    input  logic        e0_hwrite,
    input  logic        e0_sel,
    input  logic [31:0] e1_haddr,
    input  logic [2:0]  e1_hburst,
    input  logic [3:0]  e1_hprot,
    input  logic        e1_hready_in,
    input  logic [2:0]  e1_hsize,
    input  logic [1:0]  e1_htrans,
    input  logic [31:0] e1_hwdata,
    input  logic        e1_hwrite,
    input  logic        e1_sel,
    input  logic [31:0] e2_haddr,
    input  logic [2:0]  e2_hburst,
    input  logic [3:0]  e2_hprot,
    input  logic        e2_hready_in,
    input  logic [2:0]  e2_hsize,
    input  logic [1:0]  e2_htrans,
    input  logic [31:0] e2_hwdata,
    input  logic        e2_hwrite,
    input  logic        e2_sel,
    output logic [31:0] AHB_INTERFACE_0_haddr,
    output logic [2:0]  AHB_INTERFACE_0_hburst,
    output logic [3:0]  AHB_INTERFACE_0_hprot,
    output logic        AHB_INTERFACE_0_hready_in,
    output logic [2:0]  AHB_INTERFACE_0_hsize,
    output logic [1:0]  AHB_INTERFACE_0_htrans,
    output logic [31:0] AHB_INTERFACE_0_hwdata,
    output logic        AHB_INTERFACE_0_hwrite,
    output logic        AHB_INTERFACE_0_sel,
    input  logic [31:0] AHB_INTERFACE_0_hrdata,
    input  logic        AHB_INTERFACE_0_hready_out,
    input  logic        AHB_INTERFACE_0_hresp
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_START   = 3'd1;
    localparam logic [2:0] c_RUN     = 3'd2;
    localparam logic [2:0] c_DRAIN   = 3'd3;
    localparam logic [2:0] c_ENG_RST = 3'd4;
    localparam logic [2:0] c_DONE    = 3'd5;
`ifdef CNN_LAYER_SCHED_WATCHDOG_EN
    localparam logic [2:0] c_ERROR   = 3'd6;
`endif
    localparam logic [1:0] c_NONE    = 2'd3;

    logic [2:0]  r_state;
    logic [2:0]  r_en_q;
    logic [1:0]  r_idx;
    logic [1:0]  r_grant;
    logic [2:0]  r_start;
    logic [2:0]  r_rst_n;
    logic        r_rst_cnt;
    logic        r_busy;
    logic        r_done;
`ifdef CNN_LAYER_SCHED_WATCHDOG_EN
    logic [31:0] r_wd_cnt;
    logic        r_error;
`endif

    logic        w_first_valid;
    logic [1:0]  w_first_idx;
    logic        w_next_valid;
    logic [1:0]  w_next_idx;
    logic        w_cur_finish;
    logic        w_can_accept;
    logic [78:0] w_e0_bus;
    logic [78:0] w_e1_bus;
    logic [78:0] w_e2_bus;
    logic [78:0] w_port_bus;
    logic        w_unused;

    function automatic logic [2:0] f_onehot(input logic [1:0] idx);
        f_onehot = 3'b001 << idx;
    endfunction

    // Lowest enabled engine at acceptance, and the next enabled one above the current.
    always_comb begin
        w_first_valid = 1'b0;
        w_first_idx   = 2'd0;
        w_next_valid  = 1'b0;
        w_next_idx    = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (layer_en[k]) begin
                w_first_valid = 1'b1;
                w_first_idx   = 2'(k);
            end
            if (r_en_q[k] && (2'(k) > r_idx)) begin
                w_next_valid = 1'b1;
                w_next_idx   = 2'(k);
            end
        end
    end

    always_comb begin
        case (r_idx)
            2'd0:    w_cur_finish = e0_finish;
            2'd1:    w_cur_finish = e1_finish;
            2'd2:    w_cur_finish = e2_finish;
            default: w_cur_finish = 1'b0;
        endcase
    end

`ifdef CNN_LAYER_SCHED_WATCHDOG_EN
    assign w_can_accept = (r_state == c_IDLE) || (r_state == c_DONE) || (r_state == c_ERROR);
`else
    assign w_can_accept = (r_state == c_IDLE) || (r_state == c_DONE);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_IDLE;
            r_en_q    <= 3'b000;
            r_idx     <= 2'd0;
            r_grant   <= c_NONE;
            r_start   <= 3'b000;
            r_rst_n   <= 3'b000;
            r_rst_cnt <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef CNN_LAYER_SCHED_WATCHDOG_EN
            r_wd_cnt  <= 32'd0;
            r_error   <= 1'b0;
`endif
        end else if (w_can_accept && start) begin
            r_en_q  <= layer_en;
            r_rst_n <= 3'b111;
`ifdef CNN_LAYER_SCHED_WATCHDOG_EN
            r_error <= 1'b0;
`endif
            if (w_first_valid) begin
                r_state <= c_START;
                r_idx   <= w_first_idx;
                r_grant <= w_first_idx;
                r_start <= f_onehot(w_first_idx);
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
            end else begin
                r_state <= c_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_rst_n <= 3'b111;
                end
                c_START: begin
                    r_start <= 3'b000;
                    r_state <= c_RUN;
`ifdef CNN_LAYER_SCHED_WATCHDOG_EN
                    r_wd_cnt <= 32'd0;
`endif
                end
                c_RUN: begin
                    if (w_cur_finish) begin
                        r_grant <= c_NONE;
                        r_state <= c_DRAIN;
                    end
`ifdef CNN_LAYER_SCHED_WATCHDOG_EN
                    else if ((r_wd_cnt + 32'd1) >= TIMEOUT_CYCLES) begin
                        r_grant <= c_NONE;
                        r_rst_n <= r_rst_n & ~f_onehot(r_idx);
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_ERROR;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 32'd1;
                    end
`endif
                end
                c_DRAIN: begin
                    r_rst_n   <= r_rst_n & ~f_onehot(r_idx);
                    r_rst_cnt <= 1'b0;
                    r_state   <= c_ENG_RST;
                end
                c_ENG_RST: begin
                    // Engine reset is held low for exactly two cycles.
                    if (r_rst_cnt) begin
                        r_rst_n <= 3'b111;
                        if (w_next_valid) begin
                            r_state <= c_START;
                            r_idx   <= w_next_idx;
                            r_grant <= w_next_idx;
                            r_start <= f_onehot(w_next_idx);
                        end else begin
                            r_state <= c_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_rst_cnt <= 1'b1;
                    end
                end
                c_DONE: begin
                    r_done <= 1'b1;
                end
`ifdef CNN_LAYER_SCHED_WATCHDOG_EN
                c_ERROR: begin
                    r_error <= 1'b1;
                end
`endif
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign w_e0_bus = {e0_haddr, e0_hburst, e0_hprot, e0_hready_in, e0_hsize,
                       e0_htrans, e0_hwdata, e0_hwrite, e0_sel};
    assign w_e1_bus = {e1_haddr, e1_hburst, e1_hprot, e1_hready_in, e1_hsize,
                       e1_htrans, e1_hwdata, e1_hwrite, e1_sel};
    assign w_e2_bus = {e2_haddr, e2_hburst, e2_hprot, e2_hready_in, e2_hsize,
                       e2_htrans, e2_hwdata, e2_hwrite, e2_sel};

    always_comb begin
        case (r_grant)
            2'd0:    w_port_bus = w_e0_bus;
            2'd1:    w_port_bus = w_e1_bus;
            2'd2:    w_port_bus = w_e2_bus;
            default: w_port_bus = '0;
        endcase
    end

    assign {AHB_INTERFACE_0_haddr, AHB_INTERFACE_0_hburst, AHB_INTERFACE_0_hprot,
            AHB_INTERFACE_0_hready_in, AHB_INTERFACE_0_hsize, AHB_INTERFACE_0_htrans,
            AHB_INTERFACE_0_hwdata, AHB_INTERFACE_0_hwrite, AHB_INTERFACE_0_sel} = w_port_bus;

    assign busy      = r_busy;
    assign done      = r_done;
    assign cur_layer = r_grant;
    assign e0_start  = r_start[0];
    assign e1_start  = r_start[1];
    assign e2_start  = r_start[2];
    assign e0_rst_n  = r_rst_n[0];
    assign e1_rst_n  = r_rst_n[1];
    assign e2_rst_n  = r_rst_n[2];
`ifdef CNN_LAYER_SCHED_WATCHDOG_EN
    assign error     = r_error;
`else
    assign error     = 1'b0;
`endif

    // Slave responses reach the engines through top-level wiring, not through here.
    assign w_unused = ^{AHB_INTERFACE_0_hrdata, AHB_INTERFACE_0_hready_out,
                        AHB_INTERFACE_0_hresp, TIMEOUT_CYCLES};

endmodule
`default_nettype wire
